// File: rtl/hazard_unit_mc_pkg.sv
// Shared types for the hazard unit.
// Forwarding select encoding and PC register index.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    localparam int PC_IDX_DEF = 15;

endpackage

// File: rtl/hazard_unit_mc_if.sv
// Pipeline-to-hazard-unit signal bundle.
// master drives pipeline status, slave returns controls.
interface hazard_unit_mc_if #(
    parameter int AW    = 4,
    parameter int NRP   = 3,
    parameter int CNT_W = 16
);
    logic [NRP*AW-1:0] RAD;
    logic [NRP*AW-1:0] RAE;
    logic [AW-1:0]     WA3E;
    logic [AW-1:0]     WA3M;
    logic [AW-1:0]     WA3W;
    logic              RegWriteE;
    logic              RegWriteM;
    logic              RegWriteW;
    logic              MemtoRegE;
    logic              StartMcE;
    logic              PCSrcD;
    logic              PCSrcE;
    logic              PCSrcM;
    logic              PCSrcW;
    logic              BranchTakenE;
    logic              ClrCnt;
    logic [2*NRP-1:0]  ForwardE;
    logic              StallF;
    logic              StallD;
    logic              StallE;
    logic              FlushD;
    logic              FlushE;
    logic              FlushM;
    logic              McBusy;
    logic [CNT_W-1:0]  StallCycles;

    modport master (
        output RAD, RAE, WA3E, WA3M, WA3W,
        output RegWriteE, RegWriteM, RegWriteW,
        output MemtoRegE, StartMcE,
        output PCSrcD, PCSrcE, PCSrcM, PCSrcW,
        output BranchTakenE, ClrCnt,
        input  ForwardE, StallF, StallD, StallE,
        input  FlushD, FlushE, FlushM,
        input  McBusy, StallCycles
    );

    modport slave (
        input  RAD, RAE, WA3E, WA3M, WA3W,
        input  RegWriteE, RegWriteM, RegWriteW,
        input  MemtoRegE, StartMcE,
        input  PCSrcD, PCSrcE, PCSrcM, PCSrcW,
        input  BranchTakenE, ClrCnt,
        output ForwardE, StallF, StallD, StallE,
        output FlushD, FlushE, FlushM,
        output McBusy, StallCycles
    );

endinterface

// File: rtl/hazard_unit_mc_mc_stall_ctr.sv
// Multi-cycle execute occupancy counter.
// Holds E for MC_LAT-1 cycles per multi-cycle op.
module mc_stall_ctr #(
    parameter int MC_LAT = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic mc_stall,
    output logic mc_busy
);
    localparam int CW = $clog2(MC_LAT) + 1;
    localparam logic [CW-1:0] LAST = CW'(MC_LAT - 1);

    logic [CW-1:0] mc_cnt;

    assign mc_stall = start && (mc_cnt != LAST);
    assign mc_busy  = (mc_cnt != '0);

    // Count held cycles; any non-stall cycle (done or killed) clears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mc_cnt <= '0;
        end else if (mc_stall) begin
            mc_cnt <= mc_cnt + 1'b1;
        end else begin
            mc_cnt <= '0;
        end
    end

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage core: forwarding,
// load-use, PC-write, branch and multi-cycle stalls.
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int AW     = 4,
    parameter int NRP    = 3,
    parameter int MC_LAT = 3,
    parameter int PC_IDX = PC_IDX_DEF,
    parameter int CNT_W  = 16
) (
    input logic       clk,
    input logic       reset,
    hazard_unit_mc_if.slave hz
);
    localparam logic [AW-1:0] PC_A = AW'(PC_IDX);

    logic [2*NRP-1:0] fwd;
    logic [NRP-1:0]   rad_hit;
    logic             ldr_stall;
    logic             pc_wr_pend;
    logic             mc_stall;
    logic             mc_busy;
    logic             stall_f;
    logic [CNT_W-1:0] stall_cnt;

    for (genvar p = 0; p < NRP; p++) begin : g_port
        logic [AW-1:0] rae;
        logic [AW-1:0] rad;
        fwd_sel_e      sel;

        assign rae = hz.RAE[p*AW +: AW];
        assign rad = hz.RAD[p*AW +: AW];
        assign rad_hit[p] = (rad == hz.WA3E);

        // M beats W; PC reads always come from the regfile path.
        always_comb begin
            sel = FWD_RF;
            if (hz.RegWriteM && rae == hz.WA3M && rae != PC_A) begin
                sel = FWD_M;
            end else if (hz.RegWriteW && rae == hz.WA3W && rae != PC_A) begin
                sel = FWD_W;
            end
        end

        assign fwd[2*p +: 2] = sel;
    end

    mc_stall_ctr #(
        .MC_LAT (MC_LAT)
    ) u_mc (
        .clk      (clk),
        .reset    (reset),
        .start    (hz.StartMcE),
        .mc_stall (mc_stall),
        .mc_busy  (mc_busy)
    );

    assign ldr_stall  = hz.MemtoRegE & hz.RegWriteE & (|rad_hit);
    assign pc_wr_pend = hz.PCSrcD | hz.PCSrcE | hz.PCSrcM;
    assign stall_f    = ldr_stall | pc_wr_pend | mc_stall;

    assign hz.ForwardE = reset ? '0 : fwd;
    assign hz.StallF   = ~reset & stall_f;
    assign hz.StallD   = ~reset & (ldr_stall | mc_stall);
    assign hz.StallE   = ~reset & mc_stall;
    assign hz.FlushM   = ~reset & mc_stall;
    assign hz.FlushE   = ~reset & (ldr_stall | hz.BranchTakenE) & ~mc_stall;
    assign hz.FlushD   = ~reset & (pc_wr_pend | hz.PCSrcW | hz.BranchTakenE);
    assign hz.McBusy   = ~reset & mc_busy;

    // Saturating count of fetch-stall cycles; clear wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (hz.ClrCnt) begin
            stall_cnt <= '0;
        end else if (stall_f && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign hz.StallCycles = stall_cnt;

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
- Parametrised next-generation hazard unit for the 5-stage pipelined ARM core (F/D/E/M/W).
- Resolves data hazards for NRP source operands per instruction:
  - forwarding from M and W;
  - load-use stall.
- Resolves control hazards:
  - PC-write-pending stall of fetch;
  - branch flush.
- New over the previous unit: a multi-cycle execute-unit stall counter (multiply/MLA), R15 forwarding suppression, and a saturating stall-cycle performance counter.

Parameters:
- AW, 4, register address width
- NRP, 3, source-register read ports per instruction (Rn, Rm, Rs/Rd for MLA/STR)
- MC_LAT, 3, multi-cycle execute latency in cycles; 1 means single-cycle (no stall)
- PC_IDX, 15, register index of PC; never forwarded
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- RAD  in  NRP*AW  source addresses in Decode, port p at [p*AW +: AW]
- RAE  in  NRP*AW  source addresses in Execute, same packing
- WA3E, WA3M, WA3W  in  AW each  destination address in E/M/W
- RegWriteE, RegWriteM, RegWriteW  in  1 each  destination write enables
- MemtoRegE  in  1  load in Execute
- StartMcE  in  1  multi-cycle operation occupies Execute
- PCSrcD, PCSrcE, PCSrcM, PCSrcW  in  1 each  instruction writing PC in that stage
- BranchTakenE  in  1  branch resolved taken in Execute
- ClrCnt  in  1  synchronous clear of StallCycles
- ForwardE  out  2*NRP  per-port select at [2p +: 2]: 00 = regfile, 01 = ResultW, 10 = ALUOutM
- StallF, StallD, StallE  out  1 each
- FlushD, FlushE, FlushM  out  1 each
- McBusy  out  1  multi-cycle counter active
- StallCycles  out  CNT_W  cycles with StallF=1, saturating

Behaviour:
- Reset (asynchronous, level):
  - mc counter and StallCycles go to 0.
  - While reset is high, all Stall*, Flush*, McBusy and ForwardE are forced to 0.
- Forwarding, per port p, combinational:
  - 10 if RegWriteM, RAE[p]==WA3M and RAE[p]!=PC_IDX;
  - else 01 if RegWriteW, RAE[p]==WA3W and RAE[p]!=PC_IDX;
  - else 00.
  - M has priority over W.
- Load-use:
  - LDRstall = MemtoRegE & RegWriteE & (any p: RAD[p]==WA3E).
- Multi-cycle counter mc_cnt, width clog2(MC_LAT)+1:
  - McStall = StartMcE & (mc_cnt != MC_LAT-1).
  - On each clk: if McStall then mc_cnt<=mc_cnt+1, else mc_cnt<=0.
  - McStall is high for exactly MC_LAT-1 consecutive cycles; the instruction leaves E in the last cycle of its occupation.
  - MC_LAT=1 gives McStall always 0.
  - McBusy = (mc_cnt!=0).
  - If StartMcE drops mid-count (killed instruction), the counter clears on the next edge.
  - Back-to-back multi-cycle operations each get their own MC_LAT-1 stall cycles.
- PCWrPendingF = PCSrcD | PCSrcE | PCSrcM.
- Output equations:
  - StallF = LDRstall | PCWrPendingF | McStall
  - StallD = LDRstall | McStall
  - StallE = McStall
  - FlushM = McStall (bubble into M while E holds)
  - FlushE = (LDRstall | BranchTakenE) & ~McStall
  - FlushD = PCWrPendingF | PCSrcW | BranchTakenE
- Simultaneous events:
  - BranchTakenE with McStall: the multi-cycle hold wins. BranchTakenE is re-evaluated when E frees, and the flush then occurs.
  - LDRstall with McStall: FlushE suppressed; F and D hold.
- StallCycles:
  - Increments when StallF=1 and not saturated; saturates at all-ones.
  - ClrCnt has priority over increment; the cycle after ClrCnt reads 0.

Decomposition:
- Package hazard_pkg holds:
  - fwd_sel_e enum: FWD_RF=00, FWD_W=01, FWD_M=10;
  - PC_IDX default.
- One sub-module: mc_stall_ctr, which contains mc_cnt, McStall and McBusy.
- Forwarding compare is a generate loop over NRP; it is not a separate module.

Test Plan:
- RAE port0=3, WA3M=3, RegWriteM=1; WA3W=3, RegWriteW=1 -> ForwardE[1:0]=10. Then RegWriteM=0 -> 01. Then RAE port0=15 with both matching -> 00.
- Load-use: MemtoRegE=1, RegWriteE=1, WA3E=5, RAD port2=5 -> StallF=StallD=FlushE=1 for one cycle. Port-2 (Rs) match covered.
- MC_LAT=3, StartMcE held for 3 cycles -> StallF/D/E=FlushM=1 in cycles 1-2, 0 in cycle 3; McBusy=1 in cycle 2; mc_cnt 0 after. Repeat with MC_LAT=1 -> no stall.
- Reset asserted while mc_cnt=1 -> mc_cnt=0 and all outputs 0 immediately (asynchronous). After release with StartMcE=1, a full MC_LAT-1 stall restarts.
- PCSrcD, then E, then M, then W in successive cycles -> StallF=1 for 3 cycles, FlushD=1 for 4 cycles. BranchTakenE=1 alone -> FlushD=FlushE=1.
- Counter: CNT_W=4, hold StallF high 20 cycles -> StallCycles=15 (saturated). ClrCnt=1 with StallF=1 -> next cycle 0.
